// File: rtl/turn_pkg.sv
// Shared types, limits and aim helpers for the turn controller.
package turn_pkg;

    typedef enum logic [2:0] {
        StAim,
        StFire,
        StArm,
        StFlight,
        StSettle,
        StSwitch
    } turn_state_e;

    localparam logic [3:0] ANGLE_MAX    = 4'd8;
    localparam logic [2:0] POWER_MAX    = 3'd7;
    localparam logic [3:0] P0_ANGLE_DEF = 4'd6;
    localparam logic [3:0] P1_ANGLE_DEF = 4'd2;
    localparam logic [2:0] POWER_DEF    = 3'd3;

    // Saturating single step of the angle; inc and dec together leave it alone.
    function automatic logic [3:0] step_angle(input logic [3:0] cur, input logic inc,
                                              input logic dec);
        logic [3:0] res;
        res = cur;
        if (inc && !dec && cur < ANGLE_MAX) begin
            res = cur + 4'd1;
        end else if (dec && !inc && cur != 4'd0) begin
            res = cur - 4'd1;
        end
        return res;
    endfunction

    // Saturating single step of the power.
    function automatic logic [2:0] step_power(input logic [2:0] cur, input logic inc,
                                              input logic dec);
        logic [2:0] res;
        res = cur;
        if (inc && !dec && cur != POWER_MAX) begin
            res = cur + 3'd1;
        end else if (dec && !inc && cur != 3'd0) begin
            res = cur - 3'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame clock into the clk domain as a one-cycle tick.
module frame_tick_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1_q, sync2_q, prev_q, tick_q;

    // Two-flop synchroniser, rising-edge detect, registered pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= sync2_q & ~prev_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/turn_controller.sv
// Per-player aim, launch handshake to the bomb, flight tracking and turn hand-over.
module turn_controller
    import turn_pkg::*;
#(
    parameter int unsigned REPEAT_FRAMES = 8,
    parameter int unsigned ARM_FRAMES    = 4,
    parameter int unsigned FLIGHT_FRAMES = 600,
    parameter int unsigned SETTLE_FRAMES = 30,
    parameter int unsigned BARREL_OFS    = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_clk,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_fire,
    input  logic [9:0] tank0_x,
    input  logic [9:0] tank0_y,
    input  logic [9:0] tank1_x,
    input  logic [9:0] tank1_y,
    input  logic       bomb_done,
    output logic       launch,
    output logic [9:0] launchX,
    output logic [9:0] launchY,
    output logic [3:0] angle,
    output logic [2:0] power,
    output logic       active_player,
    output logic       busy
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_FRAMES - 1);
    localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_FRAMES - 1);
    localparam logic [CNT_W-1:0] FLIGHT_LAST = CNT_W'(FLIGHT_FRAMES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [9:0]       BARREL_W    = 10'(BARREL_OFS);

    logic frame_tick;

    turn_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       p0_angle_q, p0_angle_d, p1_angle_q, p1_angle_d;
    logic [2:0]       p0_power_q, p0_power_d, p1_power_q, p1_power_d;
    logic             active_q, active_d;
    logic             launch_q, launch_d;
    logic [9:0]       launch_x_q, launch_x_d, launch_y_q, launch_y_d;
    logic             fire_prev_q, fire_prev_d;
    logic [3:0]       aim_prev_q, aim_prev_d;

    logic [3:0] aim_keys, aim_step, cur_angle, new_angle;
    logic [2:0] cur_power, new_power;
    logic       fire_edge, repeat_due;

    frame_tick_sync u_frame_tick_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    // Key bits ordered {left, right, up, down}.
    assign aim_keys   = {key_left, key_right, key_up, key_down};
    assign fire_edge  = key_fire & ~fire_prev_q;
    assign repeat_due = (cnt_q == REPEAT_LAST);
    // A key steps on its first held tick and then whenever the repeat interval runs out.
    assign aim_step   = aim_keys & (~aim_prev_q | {4{repeat_due}});
    assign cur_angle  = active_q ? p1_angle_q : p0_angle_q;
    assign cur_power  = active_q ? p1_power_q : p0_power_q;
    // An opposing key held blocks the step even if only one of the pair is due.
    assign new_angle  = step_angle(cur_angle, aim_step[2] & ~aim_keys[3],
                                   aim_step[3] & ~aim_keys[2]);
    assign new_power  = step_power(cur_power, aim_step[1] & ~aim_keys[0],
                                   aim_step[0] & ~aim_keys[1]);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StAim;
            cnt_q       <= '0;
            p0_angle_q  <= P0_ANGLE_DEF;
            p1_angle_q  <= P1_ANGLE_DEF;
            p0_power_q  <= POWER_DEF;
            p1_power_q  <= POWER_DEF;
            active_q    <= 1'b0;
            launch_q    <= 1'b0;
            launch_x_q  <= '0;
            launch_y_q  <= '0;
            fire_prev_q <= 1'b1;
            aim_prev_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p0_angle_q  <= p0_angle_d;
            p1_angle_q  <= p1_angle_d;
            p0_power_q  <= p0_power_d;
            p1_power_q  <= p1_power_d;
            active_q    <= active_d;
            launch_q    <= launch_d;
            launch_x_q  <= launch_x_d;
            launch_y_q  <= launch_y_d;
            fire_prev_q <= fire_prev_d;
            aim_prev_q  <= aim_prev_d;
        end
    end

    // Next-state logic; everything advances only on a frame tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p0_angle_d  = p0_angle_q;
        p1_angle_d  = p1_angle_q;
        p0_power_d  = p0_power_q;
        p1_power_d  = p1_power_q;
        active_d    = active_q;
        launch_d    = launch_q;
        launch_x_d  = launch_x_q;
        launch_y_d  = launch_y_q;
        fire_prev_d = fire_prev_q;
        aim_prev_d  = aim_prev_q;

        if (frame_tick) begin
            fire_prev_d = key_fire;
            aim_prev_d  = '0;
            unique case (state_q)
                StAim: begin
                    if (fire_edge) begin
                        launch_x_d = active_q ? tank1_x : tank0_x;
                        launch_y_d = (active_q ? tank1_y : tank0_y) - BARREL_W;
                        launch_d   = 1'b1;
                        state_d    = StFire;
                        cnt_d      = '0;
                    end else begin
                        aim_prev_d = aim_keys;
                        if (active_q) begin
                            p1_angle_d = new_angle;
                            p1_power_d = new_power;
                        end else begin
                            p0_angle_d = new_angle;
                            p0_power_d = new_power;
                        end
                        cnt_d = (|aim_step || aim_keys == '0) ? '0 : cnt_q + 1'b1;
                    end
                end
                StFire: begin
                    // Launch has now spanned a whole frame, so the bomb has seen it.
                    launch_d = 1'b0;
                    state_d  = StArm;
                    cnt_d    = '0;
                end
                StArm: begin
                    if (!bomb_done) begin
                        state_d = StFlight;
                        cnt_d   = '0;
                    end else if (cnt_q == ARM_LAST) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StFlight: begin
                    if (bomb_done || cnt_q == FLIGHT_LAST) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = StSwitch;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StSwitch: begin
                    active_d = ~active_q;
                    state_d  = StAim;
                    cnt_d    = '0;
                end
                default: begin
                    state_d = StAim;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign launch        = launch_q;
    assign launchX       = launch_x_q;
    assign launchY       = launch_y_q;
    assign angle         = cur_angle;
    assign power         = cur_power;
    assign active_player = active_q;
    assign busy          = (state_q != StAim);

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench: random and directed frames against a tick-level turn model.
module tb_turn_controller;

    localparam int REPEAT_N = 8;
    localparam int ARM_N    = 4;
    localparam int FLIGHT_N = 600;
    localparam int SETTLE_N = 30;
    localparam int OFS      = 6;

    localparam int PH_AIM    = 0;
    localparam int PH_FIRE   = 1;
    localparam int PH_ARM    = 2;
    localparam int PH_FLIGHT = 3;
    localparam int PH_SETTLE = 4;
    localparam int PH_SWITCH = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_clk;
    logic       key_left, key_right, key_up, key_down, key_fire;
    logic [9:0] tank0_x, tank0_y, tank1_x, tank1_y;
    logic       bomb_done;
    logic       launch;
    logic [9:0] launchX, launchY;
    logic [3:0] angle;
    logic [2:0] power;
    logic       active_player, busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (tick granularity).
    int m_phase, m_n, m_ap, m_launch, m_lx, m_ly, m_fire_prev;
    int m_angle [2];
    int m_power [2];
    int m_hold  [4];

    turn_controller #(
        .REPEAT_FRAMES (REPEAT_N),
        .ARM_FRAMES    (ARM_N),
        .FLIGHT_FRAMES (FLIGHT_N),
        .SETTLE_FRAMES (SETTLE_N),
        .BARREL_OFS    (OFS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_clk     (frame_clk),
        .key_left      (key_left),
        .key_right     (key_right),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_fire      (key_fire),
        .tank0_x       (tank0_x),
        .tank0_y       (tank0_y),
        .tank1_x       (tank1_x),
        .tank1_y       (tank1_y),
        .bomb_done     (bomb_done),
        .launch        (launch),
        .launchX       (launchX),
        .launchY       (launchY),
        .angle         (angle),
        .power         (power),
        .active_player (active_player),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = PH_AIM;
        m_n         = 0;
        m_ap        = 0;
        m_launch    = 0;
        m_lx        = 0;
        m_ly        = 0;
        m_fire_prev = 1;
        m_angle[0]  = 6;
        m_angle[1]  = 2;
        m_power[0]  = 3;
        m_power[1]  = 3;
        for (int k = 0; k < 4; k++) m_hold[k] = 0;
    endtask

    // One frame of the turn rules, from the inputs held during that frame.
    task automatic model_tick();
        bit fe;
        bit held [4];
        bit st [4];
        int ty;
        fe = key_fire && (m_fire_prev == 0);
        m_fire_prev = key_fire;
        held[0] = key_left;
        held[1] = key_right;
        held[2] = key_up;
        held[3] = key_down;
        if (m_phase != PH_AIM || fe) begin
            for (int k = 0; k < 4; k++) m_hold[k] = 0;
        end
        case (m_phase)
            PH_AIM: begin
                if (fe) begin
                    m_lx     = (m_ap == 1) ? int'(tank1_x) : int'(tank0_x);
                    ty       = (m_ap == 1) ? int'(tank1_y) : int'(tank0_y);
                    m_ly     = (ty - OFS + 1024) % 1024;
                    m_launch = 1;
                    m_phase  = PH_FIRE;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        if (held[k]) begin
                            st[k] = (m_hold[k] % REPEAT_N) == 0;
                            m_hold[k]++;
                        end else begin
                            st[k] = 0;
                            m_hold[k] = 0;
                        end
                    end
                    if (!(held[0] && held[1])) begin
                        if (st[1] && m_angle[m_ap] < 8) m_angle[m_ap]++;
                        else if (st[0] && m_angle[m_ap] > 0) m_angle[m_ap]--;
                    end
                    if (!(held[2] && held[3])) begin
                        if (st[2] && m_power[m_ap] < 7) m_power[m_ap]++;
                        else if (st[3] && m_power[m_ap] > 0) m_power[m_ap]--;
                    end
                end
            end
            PH_FIRE: begin
                m_launch = 0;
                m_phase  = PH_ARM;
                m_n      = 0;
            end
            PH_ARM: begin
                m_n++;
                if (!bomb_done) begin
                    m_phase = PH_FLIGHT;
                    m_n     = 0;
                end else if (m_n == ARM_N) begin
                    m_phase = PH_SETTLE;
                    m_n     = 0;
                end
            end
            PH_FLIGHT: begin
                m_n++;
                if (bomb_done || m_n == FLIGHT_N) begin
                    m_phase = PH_SETTLE;
                    m_n     = 0;
                end
            end
            PH_SETTLE: begin
                m_n++;
                if (m_n == SETTLE_N) begin
                    m_phase = PH_SWITCH;
                    m_n     = 0;
                end
            end
            default: begin
                m_ap    = 1 - m_ap;
                m_phase = PH_AIM;
            end
        endcase
    endtask

    task automatic check_outputs();
        check_val("launch", launch, m_launch);
        check_val("launchX", launchX, m_lx);
        check_val("launchY", launchY, m_ly);
        check_val("angle", angle, m_angle[m_ap]);
        check_val("power", power, m_power[m_ap]);
        check_val("active_player", active_player, m_ap);
        check_val("busy", busy, (m_phase != PH_AIM) ? 1 : 0);
    endtask

    // One frame_clk period of 8 clks; outputs settle 4 clks after the rising edge.
    task automatic do_frame();
        @(negedge clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge clk);
        model_tick();
        check_outputs();
    endtask

    task automatic run_until_aim(input int max_frames);
        int n;
        n = 0;
        do begin
            do_frame();
            n++;
        end while (m_phase != PH_AIM && n < max_frames);
        check_val("turn_done", busy, 0);
    endtask

    task automatic set_keys(input logic [3:0] k);
        {key_left, key_right, key_up, key_down} = k;
    endtask

    initial begin
        logic [3:0] combos [8];
        int seg_left;
        combos = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0011, 4'b1010, 4'b0101};

        reset_n   = 1'b0;
        frame_clk = 1'b0;
        set_keys(4'b0000);
        key_fire  = 1'b0;
        tank0_x   = 10'd0;
        tank0_y   = 10'd0;
        tank1_x   = 10'd500;
        tank1_y   = 10'd3;
        bomb_done = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        reset_n = 1'b1;

        // Idle frames keep the reset aim.
        repeat (3) do_frame();
        check_val("idle_angle", angle, 6);
        check_val("idle_power", power, 3);

        // Held right key: step at once, repeat after 8 frames, saturate at 8.
        key_right = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            do_frame();
            if (i == 1 || i == 8) check_val("rep_angle7", angle, 7);
            if (i == 9 || i == 20) check_val("rep_angle8", angle, 8);
        end
        key_right = 1'b0;
        do_frame();

        // Fire from player 0, bomb flies 50 frames then detonates.
        tank0_x  = 10'd100;
        tank0_y  = 10'd300;
        key_fire = 1'b1;
        do_frame();
        check_val("fire_launch", launch, 1);
        check_val("fire_x", launchX, 100);
        check_val("fire_y", launchY, 294);
        key_fire  = 1'b0;
        bomb_done = 1'b0;
        do_frame();
        check_val("fire_drop", launch, 0);
        repeat (49) do_frame();
        bomb_done = 1'b1;
        run_until_aim(60);
        check_val("sw_player", active_player, 1);
        check_val("sw_angle", angle, 2);

        // Player 1 fires, bomb never leaves: ARM gives up after 4 frames.
        key_fire = 1'b1;
        do_frame();
        check_val("p1_fire_y", launchY, 1021);
        key_fire = 1'b0;
        repeat (4) do_frame();
        check_val("arm_busy", busy, 1);
        run_until_aim(40);
        check_val("arm_player", active_player, 0);

        // Stuck bomb: flight times out.
        key_fire = 1'b1;
        do_frame();
        key_fire  = 1'b0;
        bomb_done = 1'b0;
        run_until_aim(700);
        check_val("tmo_player", active_player, 1);

        // Reset in mid-flight with fire held through reset.
        key_fire = 1'b1;
        do_frame();
        key_fire = 1'b0;
        repeat (10) do_frame();
        key_fire = 1'b1;
        do_frame();
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_launch", launch, 0);
        check_val("rst_lx", launchX, 0);
        check_val("rst_ly", launchY, 0);
        check_val("rst_angle", angle, 6);
        check_val("rst_power", power, 3);
        check_val("rst_player", active_player, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clk);
        reset_n   = 1'b1;
        bomb_done = 1'b1;
        repeat (4) do_frame();
        check_val("held_fire_launch", launch, 0);
        key_fire = 1'b0;

        // Random play.
        seg_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (seg_left == 0) begin
                if ({key_left, key_right, key_up, key_down} != 4'b0000) begin
                    set_keys(4'b0000);
                    seg_left = $urandom_range(1, 2);
                end else begin
                    set_keys(combos[$urandom_range(0, 7)]);
                    seg_left = $urandom_range(1, 20);
                end
            end
            seg_left--;
            key_fire = ($urandom_range(0, 9) == 0);
            if (m_phase == PH_FIRE || m_phase == PH_ARM) bomb_done = ($urandom_range(0, 3) == 0);
            else if (m_phase == PH_FLIGHT) bomb_done = ($urandom_range(0, 24) == 0);
            else bomb_done = 1'b1;
            tank0_x = 10'($urandom);
            tank0_y = 10'($urandom);
            tank1_x = 10'($urandom);
            tank1_y = 10'($urandom);
            do_frame();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
